// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Wraps an external combinational ALU with a request/response sequencer.
//   A transaction accepted on the in_* handshake is driven onto alu_*; the
//   inputs are held for SETTLE cycles, then alu_result is captured together
//   with carry/overflow/zero/negative status and offered on the out_*
//   handshake.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake, operands in_a/in_b, opcode in_op
//                        (00 add, 01 sub A-B, 10 AND, 11 OR)
//   alu_a/alu_b/alu_op   registered drive to the ALU
//   alu_result           ALU result, sampled only on the capture edge
//   out_valid/out_ready  downstream handshake
//   out_result/out_op    captured result and its opcode
//   out_carry/out_ovf    carry (add) / borrow (sub), signed overflow
//   out_zero/out_neg     result zero / result sign bit
//   busy                 sequencer is not idle
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [1:0]       out_op,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam int           MSB      = WIDTH - 1;
    localparam logic [3:0]   CNT_LOAD = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    // The ALU input registers double as the operand copies used for the
    // flags: they are held constant from acceptance through capture.
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    // Flag arithmetic, evaluated from the held operands and live ALU result.
    logic [WIDTH-1:0] sum_w;
    logic             carry_c, ovf_c;

    assign sum_w = alu_a_q + alu_b_q;

    always_comb begin
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (alu_op_q)
            2'b00: begin
                // Unsigned wrap of the truncated sum marks the carry-out.
                carry_c = (sum_w < alu_a_q);
                ovf_c   = (alu_a_q[MSB] == alu_b_q[MSB]) &&
                          (alu_result[MSB] != alu_a_q[MSB]);
            end
            2'b01: begin
                carry_c = (alu_a_q < alu_b_q);
                ovf_c   = (alu_a_q[MSB] != alu_b_q[MSB]) &&
                          (alu_result[MSB] != alu_a_q[MSB]);
            end
            default: begin
                carry_c = 1'b0;
                ovf_c   = 1'b0;
            end
        endcase
    end

    // Next-state and datapath.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        res_d    = res_q;
        op_d     = op_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_a_d  = in_a;
                    alu_b_d  = in_b;
                    alu_op_d = in_op;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    op_d    = alu_op_q;
                    carry_d = carry_c;
                    ovf_d   = ovf_c;
                    zero_d  = (alu_result == '0);
                    neg_d   = alu_result[MSB];
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            res_q    <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            res_q    <= res_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_HOLD);
    assign busy       = (state_q != ST_IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign out_result = res_q;
    assign out_op     = op_q;
    assign out_carry  = carry_q;
    assign out_ovf    = ovf_q;
    assign out_zero   = zero_q;
    assign out_neg    = neg_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Bench for alu_op_sequencer: a behavioural ALU closes the loop, a vector
//   table of operands with hand-computed results drives the main instance
//   (SETTLE=4), a scoreboard queue matches accepted requests to delivered
//   results, and hand-written sequences cover reset, backpressure and a
//   second instance with SETTLE=1.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int W  = 8;
    localparam int ST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    // main instance (SETTLE=4)
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
    logic [1:0]   in_op, alu_op, out_op;
    logic         out_carry, out_ovf, out_zero, out_neg;
    // second instance (SETTLE=1)
    logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic [W-1:0] in_a1, in_b1, alu_a1, alu_b1, alu_result1, out_result1;
    logic [1:0]   in_op1, alu_op1, out_op1;
    logic         out_carry1, out_ovf1, out_zero1, out_neg1;

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_result  = alu_f(alu_a, alu_b, alu_op);
    assign alu_result1 = alu_f(alu_a1, alu_b1, alu_op1);

    alu_op_sequencer #(.WIDTH(W), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero), .out_neg(out_neg),
        .busy(busy)
    );

    alu_op_sequencer #(.WIDTH(W), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_op(in_op1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_result(alu_result1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_result(out_result1), .out_op(out_op1),
        .out_carry(out_carry1), .out_ovf(out_ovf1), .out_zero(out_zero1), .out_neg(out_neg1),
        .busy(busy1)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] r;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc;
    } exp_t;

    vec_t vecs [9];
    vec_t cur;
    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_hs  = 0;
    int   last_acc = 0;
    logic ov_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event did not occur within bound", nm);
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev && exp_q.size() > 0)
                chk("latency", cyc - exp_q[0].acc, ST);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got out_valid expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", out_result, e.v.r);
                    chk("op",     out_op,     e.v.op);
                    chk("carry",  out_carry,  e.v.c);
                    chk("ovf",    out_ovf,    e.v.v);
                    chk("zero",   out_zero,   e.v.z);
                    chk("neg",    out_neg,    e.v.n);
                    last_hs = cyc + 1;
                end
            end
            if (in_valid && in_ready) begin
                e.v   = cur;
                e.acc = cyc + 1;
                exp_q.push_back(e);
                last_acc = cyc + 1;
            end
            ov_prev = out_valid;
        end
    end

    task automatic drive(input int i);
        cur      = vecs[i];
        in_a     = vecs[i].a;
        in_b     = vecs[i].b;
        in_op    = vecs[i].op;
        in_valid = 1'b1;
    endtask

    // Waits for the accept, then drops in_valid right after the accept edge.
    task automatic wait_acc();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        //           a      b      op     r      c     v     z     n
        vecs[0] = '{8'h2B, 8'h1E, 2'b00, 8'h49, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h2B, 8'h1E, 2'b01, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h2B, 8'h1E, 2'b10, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h2B, 8'h1E, 2'b11, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hF9, 8'h5F, 2'b00, 8'h58, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'hF9, 8'h5F, 2'b01, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h4B, 8'h85, 2'b01, 8'hC6, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h4B, 8'h85, 2'b00, 8'hD0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_op1 = '0; out_ready1 = 1'b1;
        cur = vecs[0];

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,   1);
        chk("rst_out_valid", out_valid,  0);
        chk("rst_busy",      busy,       0);
        chk("rst_alu_a",     alu_a,      0);
        chk("rst_out_res",   out_result, 0);
        chk("rst_out_zero",  out_zero,   0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table of vectors, out_ready held high.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1 drive(i);
            wait_acc();
            wait_drain();
        end

        // Backpressure: hold in HOLD for 10 cycles while upstream wiggles.
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(6);
        wait_acc();
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("hold_timeout");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 8'($urandom);
            @(negedge clk);
            chk("bp_in_ready",  in_ready,   0);
            chk("bp_out_valid", out_valid,  1);
            chk("bp_busy",      busy,       1);
            chk("bp_out_res",   out_result, 8'hC6);
            chk("bp_out_carry", out_carry,  1);
            chk("bp_alu_a",     alu_a,      8'h4B);
            chk("bp_alu_b",     alu_b,      8'h85);
            chk("bp_alu_op",    alu_op,     2'b01);
        end
        // Release and offer the next request in the same cycle.
        @(posedge clk);
        #1 out_ready = 1'b1;
        drive(0);
        wait_acc();
        chk("accept_gap", last_acc - last_hs, 1);
        wait_drain();
        @(negedge clk);
        chk("post_res_kept", out_result, 8'h49);

        // Reset in the middle of SETTLE aborts the transaction.
        @(posedge clk);
        #1 drive(1);
        wait_acc();
        #1 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_out_valid", out_valid, 0);
        end
        chk("mid_rst_in_ready", in_ready,   1);
        chk("mid_rst_busy",     busy,       0);
        chk("mid_rst_alu_a",    alu_a,      0);
        chk("mid_rst_alu_b",    alu_b,      0);
        chk("mid_rst_alu_op",   alu_op,     0);
        chk("mid_rst_out_res",  out_result, 0);
        chk("mid_rst_out_op",   out_op,     0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_no_out", out_valid, 0);
        end

        // SETTLE=1 instance: result on the edge after the accept.
        @(posedge clk);
        #1;
        in_a1 = 8'h80; in_b1 = 8'h80; in_op1 = 2'b00; in_valid1 = 1'b1;
        @(negedge clk);
        chk("s1_in_ready",  in_ready1,  1);
        chk("s1_pre_valid", out_valid1, 0);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        chk("s1_busy",      busy1,      1);
        @(posedge clk);
        @(negedge clk);
        chk("s1_out_valid", out_valid1, 1);
        chk("s1_result",    out_result1, 8'h00);
        chk("s1_op",        out_op1,    2'b00);
        chk("s1_zero",      out_zero1,  1);
        chk("s1_carry",     out_carry1, 1);
        chk("s1_ovf",       out_ovf1,   1);
        chk("s1_neg",       out_neg1,   0);
        @(posedge clk);
        @(negedge clk);
        chk("s1_drained",   out_valid1, 0);
        chk("s1_ready",     in_ready1,  1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
